// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
// Shared definitions for the push-button conditioner:
//   - key_state_e : 2-bit FSM state encoding (IDLE=0, PRESS_WAIT=1, DOWN=2,
//                   RELEASE_WAIT=3)
//   - default timing constants for a 50 MHz system clock
//   - cnt_width() : width of a counter that runs 0 .. terminal-1
// -----------------------------------------------------------------------------
package key_debounce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_DOWN         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } key_state_e;

   // 20 ms debounce, 1 s long-press, 200 ms auto-repeat at 50 MHz
   localparam int unsigned KEY_DEBOUNCE_DEF = 1_000_000;
   localparam int unsigned KEY_LONG_DEF     = 50_000_000;
   localparam int unsigned KEY_REPEAT_DEF   = 10_000_000;

   // A counter that is cleared on reaching terminal-1 needs $clog2(terminal)
   // bits; keep at least one bit for degenerate terminals.
   function automatic int unsigned cnt_width(input int unsigned terminal);
      return (terminal < 2) ? 1 : $clog2(terminal);
   endfunction

endpackage

// File: rtl/key_sync.sv
// -----------------------------------------------------------------------------
// key_sync
// Two-flop synchroniser bringing an asynchronous pin into the clk domain.
// Both flops reset to RESET_VAL so that the pin appears at a chosen level
// (normally "not pressed") straight out of reset.
//
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   d_async in  asynchronous input pin
//   d_sync  out synchronised copy of d_async (two clk cycles of latency)
// -----------------------------------------------------------------------------
module key_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_async,
   output logic d_sync
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d_async;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign d_sync = sync_q;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Conditions one mechanical push-button: synchronises the raw pin, debounces
// it and produces clean single-cycle events for press, release, long-press and
// auto-repeat, plus the debounced pressed level. One instance per key.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples needed to accept a level change (>= 2)
//   LONG_CYCLES      DOWN-state cycles after key_press until key_long
//   REPEAT_CYCLES    DOWN-state cycles between key_repeat pulses (>= 2)
//   ACTIVE_LOW       1: the pin reads 0 while pressed
//
// Ports:
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   key_raw      in  raw, bouncing, asynchronous pin
//   key_press    out one-cycle pulse on accepted press
//   key_release  out one-cycle pulse on accepted release
//   key_long     out one-cycle pulse after LONG_CYCLES of hold
//   key_repeat   out one-cycle pulse every REPEAT_CYCLES after key_long
//   key_level    out debounced pressed level
// -----------------------------------------------------------------------------
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
   parameter int unsigned LONG_CYCLES     = KEY_LONG_DEF,
   parameter int unsigned REPEAT_CYCLES   = KEY_REPEAT_DEF,
   parameter int unsigned ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_repeat,
   output logic key_level
);

   localparam int unsigned DCNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int unsigned HCNT_W   = cnt_width(HOLD_MAX);

   localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HCNT_W-1:0] LONG_LAST   = HCNT_W'(LONG_CYCLES - 1);
   localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_CYCLES - 1);

   // Pin level while the key is not pressed; also the synchroniser reset value
   localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

   logic key_sync_w;
   logic pressed;

   key_state_e        state_q, state_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic              long_q, long_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_pulse_q, long_pulse_d;
   logic              repeat_q, repeat_d;
   logic              level_q, level_d;

   key_sync #(
      .RESET_VAL (PIN_IDLE)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_async (key_raw),
      .d_sync  (key_sync_w)
   );

   // Normalise polarity: 1 = pressed
   assign pressed = key_sync_w ^ PIN_IDLE;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         dcnt_q       <= '0;
         hcnt_q       <= '0;
         long_q       <= 1'b0;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         long_pulse_q <= 1'b0;
         repeat_q     <= 1'b0;
         level_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         dcnt_q       <= dcnt_d;
         hcnt_q       <= hcnt_d;
         long_q       <= long_d;
         press_q      <= press_d;
         release_q    <= release_d;
         long_pulse_q <= long_pulse_d;
         repeat_q     <= repeat_d;
         level_q      <= level_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pressed) state_d = ST_PRESS_WAIT;
         end
         ST_PRESS_WAIT: begin
            if (!pressed)                state_d = ST_IDLE;
            else if (dcnt_q == DCNT_LAST) state_d = ST_DOWN;
         end
         ST_DOWN: begin
            if (!pressed) state_d = ST_RELEASE_WAIT;
         end
         ST_RELEASE_WAIT: begin
            if (pressed)                 state_d = ST_DOWN;
            else if (dcnt_q == DCNT_LAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counters, long flag and event pulses
   always_comb begin
      dcnt_d       = dcnt_q;
      hcnt_d       = hcnt_q;
      long_d       = long_q;
      press_d      = 1'b0;
      release_d    = 1'b0;
      long_pulse_d = 1'b0;
      repeat_d     = 1'b0;
      // Level follows the accepted state, so it changes on the same edge as
      // the press/release pulse.
      level_d      = (state_d == ST_DOWN) || (state_d == ST_RELEASE_WAIT);

      case (state_q)
         ST_IDLE: begin
            dcnt_d = '0;
         end
         ST_PRESS_WAIT: begin
            if (!pressed) begin
               dcnt_d = '0;
            end else if (dcnt_q == DCNT_LAST) begin
               press_d = 1'b1;
               dcnt_d  = '0;
               hcnt_d  = '0;
               long_d  = 1'b0;
            end else begin
               dcnt_d = dcnt_q + DCNT_W'(1);
            end
         end
         ST_DOWN: begin
            if (!pressed) begin
               dcnt_d = '0;
            end else if (!long_q && (hcnt_q == LONG_LAST)) begin
               long_pulse_d = 1'b1;
               long_d       = 1'b1;
               hcnt_d       = '0;
            end else if (long_q && (hcnt_q == REPEAT_LAST)) begin
               repeat_d = 1'b1;
               hcnt_d   = '0;
            end else begin
               hcnt_d = hcnt_q + HCNT_W'(1);
            end
         end
         ST_RELEASE_WAIT: begin
            // A release bounce returns to DOWN with the hold count and long
            // flag untouched, so an absorbed bounce does not restart timing.
            if (pressed) begin
               dcnt_d = '0;
            end else if (dcnt_q == DCNT_LAST) begin
               release_d = 1'b1;
               dcnt_d    = '0;
            end else begin
               dcnt_d = dcnt_q + DCNT_W'(1);
            end
         end
         default: begin
            dcnt_d = '0;
         end
      endcase
   end

   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_long    = long_pulse_q;
   assign key_repeat  = repeat_q;
   assign key_level   = level_q;

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

   localparam int D = 4;
   localparam int L = 20;
   localparam int R = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic key_raw;
   logic key_press, key_release, key_long, key_repeat, key_level;
   logic [4:0] outs;

   always #5 clk = ~clk;

   key_debounce #(
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L),
      .REPEAT_CYCLES   (R),
      .ACTIVE_LOW      (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_raw),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long),
      .key_repeat  (key_repeat),
      .key_level   (key_level)
   );

   assign outs = {key_press, key_release, key_long, key_repeat, key_level};

   int total = 0;
   int bad   = 0;

   // Reference model: the pin as seen two edges late, a run length of samples
   // disagreeing with the accepted level, and a count of held cycles since the
   // last accepted press.
   bit m_h1, m_h2, m_level;
   int m_run, m_hold;
   bit m_press, m_rel, m_long, m_rep;

   int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0;
   int alt_state = 0;

   typedef struct {
      bit raw;
      int cycles;
      int n_p;
      int n_r;
      int n_l;
      int n_rp;
      bit lvl;
   } seg_t;

   seg_t segs[15];

   int p0, r0, l0, rp0;
   int found, long_at, rep_n;
   int rep_at[4];
   int lvl_ok;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_h1 = 1'b1;
      m_h2 = 1'b1;
      m_level = 1'b0;
      m_run = 0;
      m_hold = 0;
      m_press = 1'b0;
      m_rel = 1'b0;
      m_long = 1'b0;
      m_rep = 1'b0;
   endtask

   task automatic model_step();
      bit smp;
      bit in_down;
      m_press = 1'b0;
      m_rel = 1'b0;
      m_long = 1'b0;
      m_rep = 1'b0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      smp = ~m_h2;
      in_down = m_level && (m_run == 0);
      if (smp != m_level) begin
         m_run++;
         if (m_run == D + 1) begin
            m_level = ~m_level;
            m_run = 0;
            if (m_level) begin
               m_press = 1'b1;
               m_hold = 0;
            end else begin
               m_rel = 1'b1;
            end
         end
      end else begin
         if (in_down) begin
            m_hold++;
            if (m_hold == L) m_long = 1'b1;
            else if (m_hold > L && ((m_hold - L) % R) == 0) m_rep = 1'b1;
         end
         m_run = 0;
      end
      m_h2 = m_h1;
      m_h1 = key_raw;
   endtask

   task automatic tick();
      logic [4:0] expv;
      @(posedge clk);
      model_step();
      #1;
      expv = {m_press, m_rel, m_long, m_rep, m_level};
      check("model", int'(outs), int'(expv));
      if (key_press) begin
         n_press++;
         check("alt_press", alt_state, 0);
         alt_state = 1;
      end
      if (key_release) begin
         n_rel++;
         check("alt_release", alt_state, 1);
         alt_state = 0;
      end
      if (key_long) n_long++;
      if (key_repeat) n_rep++;
      if (!rst_n) alt_state = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      segs[0]  = '{1'b1, 10, 0, 0, 0, 0, 1'b0};
      segs[1]  = '{1'b0,  2, 0, 0, 0, 0, 1'b0};
      segs[2]  = '{1'b1,  3, 0, 0, 0, 0, 1'b0};
      segs[3]  = '{1'b0,  2, 0, 0, 0, 0, 1'b0};
      segs[4]  = '{1'b1,  3, 0, 0, 0, 0, 1'b0};
      segs[5]  = '{1'b0, 10, 1, 0, 0, 0, 1'b1};
      segs[6]  = '{1'b0, 27, 0, 0, 1, 1, 1'b1};
      segs[7]  = '{1'b1,  2, 0, 0, 0, 0, 1'b1};
      segs[8]  = '{1'b0,  2, 0, 0, 0, 0, 1'b1};
      segs[9]  = '{1'b0,  2, 0, 0, 0, 0, 1'b1};
      segs[10] = '{1'b1, 10, 0, 1, 0, 0, 1'b0};
      segs[11] = '{1'b1,  8, 0, 0, 0, 0, 1'b0};
      segs[12] = '{1'b0,  6, 0, 0, 0, 0, 1'b0};
      segs[13] = '{1'b0,  1, 1, 0, 0, 0, 1'b1};
      segs[14] = '{1'b1, 20, 0, 1, 0, 0, 1'b0};

      // Reset state
      rst_n = 1'b0;
      key_raw = 1'b1;
      model_reset();
      #2;
      check("reset_outputs", int'(outs), 0);
      repeat (3) tick();
      rst_n = 1'b1;

      // Table of constant-level segments with expected event counts
      for (int i = 0; i < 15; i++) begin
         p0 = n_press; r0 = n_rel; l0 = n_long; rp0 = n_rep;
         key_raw = segs[i].raw;
         repeat (segs[i].cycles) tick();
         check($sformatf("seg%0d_press", i),   n_press - p0, segs[i].n_p);
         check($sformatf("seg%0d_release", i), n_rel - r0,   segs[i].n_r);
         check($sformatf("seg%0d_long", i),    n_long - l0,  segs[i].n_l);
         check($sformatf("seg%0d_repeat", i),  n_rep - rp0,  segs[i].n_rp);
         check($sformatf("seg%0d_level", i),   int'(key_level), int'(segs[i].lvl));
      end

      // Clean press latency, then long hold with repeats
      key_raw = 1'b1;
      repeat (10) tick();
      key_raw = 1'b0;
      found = -1;
      for (int e = 0; e < 20 && found < 0; e++) begin
         tick();
         if (key_press) found = e;
      end
      check("press_latency", found, D + 2);
      check("press_level", int'(key_level), 1);
      long_at = -1;
      rep_n = 0;
      for (int k = 0; k < 4; k++) rep_at[k] = -1;
      p0 = n_press; r0 = n_rel;
      for (int rel = 1; rel <= 58; rel++) begin
         tick();
         if (key_long) long_at = rel;
         if (key_repeat) begin
            if (rep_n < 4) rep_at[rep_n] = rel;
            rep_n++;
         end
      end
      check("long_at", long_at, 20);
      check("repeat_count", rep_n, 4);
      for (int k = 0; k < 4; k++) check($sformatf("repeat_at%0d", k), rep_at[k], 28 + 8 * k);
      check("hold_no_press_release", (n_press - p0) + (n_rel - r0), 0);

      // Release bounce absorbed, then a clean release
      key_raw = 1'b1;
      tick(); tick();
      key_raw = 1'b0;
      p0 = n_press; r0 = n_rel;
      lvl_ok = 1;
      repeat (10) begin
         tick();
         if (!key_level) lvl_ok = 0;
      end
      check("rb_no_release", n_rel - r0, 0);
      check("rb_no_press", n_press - p0, 0);
      check("rb_level_held", lvl_ok, 1);
      key_raw = 1'b1;
      found = -1;
      for (int e = 0; e < 20 && found < 0; e++) begin
         tick();
         if (key_release) found = e;
      end
      check("release_latency", found, D + 2);
      check("release_level", int'(key_level), 0);

      // Bounce rejection: three short low glitches
      repeat (8) tick();
      p0 = n_press; r0 = n_rel; l0 = n_long; rp0 = n_rep;
      lvl_ok = 1;
      repeat (3) begin
         key_raw = 1'b0;
         repeat (2) begin tick(); if (key_level) lvl_ok = 0; end
         key_raw = 1'b1;
         repeat (3) begin tick(); if (key_level) lvl_ok = 0; end
      end
      repeat (10) begin tick(); if (key_level) lvl_ok = 0; end
      check("bounce_no_pulses", (n_press - p0) + (n_rel - r0) + (n_long - l0) + (n_rep - rp0), 0);
      check("bounce_level_low", lvl_ok, 1);

      // Reset while held in DOWN
      key_raw = 1'b0;
      repeat (12) tick();
      check("pre_reset_level", int'(key_level), 1);
      rst_n = 1'b0;
      model_reset();
      alt_state = 0;
      #2;
      check("reset_mid_press_outputs", int'(outs), 0);
      tick(); tick();
      rst_n = 1'b1;
      found = -1;
      for (int e = 0; e < 20 && found < 0; e++) begin
         tick();
         if (key_press) found = e;
      end
      check("press_after_reset", found, D + 2);
      key_raw = 1'b1;
      repeat (12) tick();

      // Random press/release sequences with bounce prefixes
      p0 = n_press; r0 = n_rel;
      for (int s = 0; s < 10; s++) begin
         for (int ph = 0; ph < 2; ph++) begin
            logic v;
            int nb;
            v = (ph == 0) ? 1'b0 : 1'b1;
            nb = int'($urandom_range(0, 3));
            repeat (nb) begin
               key_raw = v;
               repeat ($urandom_range(1, 3)) tick();
               key_raw = ~v;
               repeat ($urandom_range(1, 3)) tick();
            end
            key_raw = v;
            repeat ($urandom_range(6, (ph == 0) ? 50 : 20)) tick();
         end
      end
      key_raw = 1'b1;
      repeat (10) tick();
      check("rand_press_count", n_press - p0, 10);
      check("rand_release_count", n_rel - r0, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
